// File: rtl/contador_ctrl.sv
// ---------------------------------------------------------------------------
// contador_ctrl
//
// Run/pause/step controller for a 4-bit display counter. It conditions three
// raw push buttons, decides when the external counter advances or clears, and
// keeps a shadow copy of the counter position.
//
// Each button passes through a 2-flop synchronizer and then a debouncer. The
// debouncer turns every accepted 0->1 level change into a one-cycle press
// event. An IDLE/RUN/PAUSE state machine consumes these events. When events
// arrive together, stop wins over start, and start wins over step.
//
// Parameters
//   DIV : clock cycles per counter advance while running (>= 2)
//   DEB : consecutive stable cycles needed to accept a button change (>= 1)
//
// Ports
//   clock     : system clock, rising edge
//   rst       : asynchronous, active-high reset
//   btn_start : raw start/resume button
//   btn_stop  : raw pause/abort button
//   btn_step  : raw single-step button
//   sw_modo   : requested count direction (0 forward, 1 reverse)
//   sw_lap    : one-lap mode; a run stops by itself after position 15 wraps
//   cnt_tick  : one-cycle advance pulse to the display counter
//   cnt_clr   : one-cycle clear pulse to the display counter
//   modo      : direction select, frozen while running
//   pos       : shadow copy of the display counter position
//   busy      : high while the state machine is in RUN
//   lap_done  : one-cycle pulse when a one-lap run completes
// ---------------------------------------------------------------------------
module contador_ctrl #(
  parameter int DIV = 50000000,
  parameter int DEB = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_step,
  input  logic       sw_modo,
  input  logic       sw_lap,
  output logic       cnt_tick,
  output logic       cnt_clr,
  output logic       modo,
  output logic [3:0] pos,
  output logic       busy,
  output logic       lap_done
);

  localparam int PW = $clog2(DIV);
  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Button lanes: bit 0 start, bit 1 stop, bit 2 step.
  logic [2:0] btn_raw;
  logic [2:0] press_ev;

  assign btn_raw = {btn_step, btn_stop, btn_start};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          level_reg;
      logic          press_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          level_reg <= 1'b0;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg != level_reg) begin
            // The DEB-th consecutive differing cycle flips the level. The
            // press event is registered together with the level, so both
            // rise in the same cycle.
            if (cnt_reg == DEB_MAX) begin
              level_reg <= sync2_reg;
              press_reg <= sync2_reg;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            // Any agreeing cycle breaks the run and restarts the count.
            cnt_reg <= '0;
          end
        end
      end

      assign press_ev[gi] = press_reg;
    end
  endgenerate

  logic ev_start;
  logic ev_stop;
  logic ev_step;

  assign ev_start = press_ev[0];
  assign ev_stop  = press_ev[1];
  assign ev_step  = press_ev[2];

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [3:0]    pos_reg;
  logic          tick_reg;
  logic          clr_reg;
  logic          modo_reg;
  logic          busy_reg;
  logic          lap_reg;
  logic          presc_wrap;

  assign presc_wrap = (presc_reg == PRE_MAX);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      pos_reg   <= 4'd0;
      tick_reg  <= 1'b0;
      clr_reg   <= 1'b0;
      modo_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      lap_reg   <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      clr_reg  <= 1'b0;
      lap_reg  <= 1'b0;

      // Direction follows the switch except while a run is in progress.
      if (state_reg != RUN) begin
        modo_reg <= sw_modo;
      end

      case (state_reg)
        IDLE: begin
          if (ev_start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            clr_reg   <= 1'b1;
            pos_reg   <= 4'd0;
            presc_reg <= '0;
          end
        end

        RUN: begin
          if (presc_wrap) begin
            // A tick is always issued on the wrap cycle, even when stop
            // arrives in that same cycle.
            presc_reg <= '0;
            tick_reg  <= 1'b1;
            pos_reg   <= pos_reg + 4'd1;
            if (sw_lap && (pos_reg == 4'd15)) begin
              lap_reg   <= 1'b1;
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else if (ev_stop) begin
              state_reg <= PAUSE;
              busy_reg  <= 1'b0;
            end
          end else if (ev_stop) begin
            // The prescaler holds its value so a resume keeps the phase.
            state_reg <= PAUSE;
            busy_reg  <= 1'b0;
          end else begin
            presc_reg <= presc_reg + 1'b1;
          end
        end

        PAUSE: begin
          if (ev_stop) begin
            state_reg <= IDLE;
            clr_reg   <= 1'b1;
            pos_reg   <= 4'd0;
            presc_reg <= '0;
          end else if (ev_start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end else if (ev_step) begin
            tick_reg <= 1'b1;
            pos_reg  <= pos_reg + 4'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_tick = tick_reg;
  assign cnt_clr  = clr_reg;
  assign modo     = modo_reg;
  assign pos      = pos_reg;
  assign busy     = busy_reg;
  assign lap_done = lap_reg;

endmodule

// File: tb/tb_contador_ctrl.sv
// ---------------------------------------------------------------------------
// tb_contador_ctrl
//
// Directed bench for contador_ctrl with DIV=4 and DEB=3. Stimulus changes and
// checks happen on falling edges. A monitor counts tick, clear and lap pulses
// shortly after each rising edge.
//
// A press held for 6 cycles produces a debounced event 5 edges after the
// button goes high. The state machine reacts on the 6th edge.
// ---------------------------------------------------------------------------
module tb_contador_ctrl;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_step = 1'b0;
  logic       sw_modo = 1'b0;
  logic       sw_lap = 1'b0;
  logic       cnt_tick;
  logic       cnt_clr;
  logic       modo;
  logic [3:0] pos;
  logic       busy;
  logic       lap_done;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;
  int clr_cnt = 0;
  int lap_cnt = 0;
  int both_hi = 0;

  contador_ctrl #(.DIV(4), .DEB(3)) dut (
    .clock     (clock),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_step  (btn_step),
    .sw_modo   (sw_modo),
    .sw_lap    (sw_lap),
    .cnt_tick  (cnt_tick),
    .cnt_clr   (cnt_clr),
    .modo      (modo),
    .pos       (pos),
    .busy      (busy),
    .lap_done  (lap_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #2;
    if (cnt_tick === 1'b1) tick_cnt++;
    if (cnt_clr === 1'b1) clr_cnt++;
    if (lap_done === 1'b1) lap_cnt++;
    if (cnt_tick === 1'b1 && cnt_clr === 1'b1) both_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int base_t;
    int base_c;
    int seen;

    // Reset state.
    cyc(2);
    chk("reset_outputs", 32'({cnt_tick, cnt_clr, modo, pos, busy, lap_done}), 32'h0);
    rst = 1'b0;
    cyc(1);

    // A glitch that is too short produces no event.
    btn_start = 1'b1;
    cyc(2);
    btn_start = 1'b0;
    cyc(8);
    chk("short_press_busy", 32'(busy), 32'h0);
    chk("short_press_outputs", 32'({cnt_tick, cnt_clr, modo, pos, lap_done}), 32'h0);
    chk("short_press_clr_cnt", 32'(clr_cnt), 32'h0);

    // A valid start gives one clear pulse, then a tick every 4 cycles.
    btn_start = 1'b1;
    cyc(6);
    chk("start_clr", 32'(cnt_clr), 32'h1);
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_pos", 32'(pos), 32'h0);
    btn_start = 1'b0;
    cyc(4);
    chk("tick1", 32'({cnt_tick, pos}), 32'h11);
    cyc(1);
    chk("tick1_gap", 32'(cnt_tick), 32'h0);
    cyc(3);
    chk("tick2", 32'({cnt_tick, pos}), 32'h12);
    cyc(4);
    chk("tick3", 32'({cnt_tick, pos}), 32'h13);
    chk("start_clr_cnt", 32'(clr_cnt), 32'h1);

    // Stop during RUN. The direction switch changes, but modo stays frozen
    // until PAUSE.
    btn_stop = 1'b1;
    sw_modo  = 1'b1;
    cyc(4);
    chk("tick4_before_pause", 32'({cnt_tick, pos}), 32'h14);
    cyc(1);
    chk("run_modo_frozen", 32'({busy, modo}), 32'h2);
    cyc(1);
    chk("pause_entered", 32'({busy, cnt_tick, pos}), 32'h04);
    btn_stop = 1'b0;
    cyc(1);
    chk("pause_modo", 32'(modo), 32'h1);
    cyc(7);

    // Two single steps while paused.
    base_t = tick_cnt;
    btn_step = 1'b1;
    cyc(6);
    chk("step1_tick", 32'({cnt_tick, pos}), 32'h15);
    btn_step = 1'b0;
    cyc(8);
    btn_step = 1'b1;
    cyc(6);
    btn_step = 1'b0;
    cyc(8);
    chk("step_tick_count", 32'(tick_cnt - base_t), 32'd2);
    chk("step_pos", 32'({busy, pos}), 32'h06);

    // A second stop aborts to IDLE with a clear.
    btn_stop = 1'b1;
    cyc(6);
    chk("abort_clr", 32'({cnt_clr, busy, pos}), 32'h20);
    btn_stop = 1'b0;
    cyc(8);
    chk("abort_clr_cnt", 32'(clr_cnt), 32'd2);

    // Start and stop events in the same cycle during RUN: stop wins.
    btn_start = 1'b1;
    cyc(6);
    chk("run2_busy", 32'(busy), 32'h1);
    btn_start = 1'b0;
    cyc(8);
    btn_start = 1'b1;
    btn_stop  = 1'b1;
    cyc(6);
    chk("simul_pause", 32'(busy), 32'h0);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    cyc(8);
    chk("simul_stays_paused", 32'(busy), 32'h0);
    btn_stop = 1'b1;
    cyc(6);
    chk("simul_abort_clr", 32'({cnt_clr, pos}), 32'h10);
    btn_stop = 1'b0;
    cyc(8);

    // One-lap run: 16 ticks, lap_done together with the last one.
    sw_lap  = 1'b1;
    sw_modo = 1'b0;
    base_c  = clr_cnt;
    btn_start = 1'b1;
    cyc(6);
    base_t = tick_cnt;
    btn_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (lap_done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("lap_seen", 32'(seen), 32'h1);
    chk("lap_tick_count", 32'(tick_cnt - base_t), 32'd16);
    chk("lap_coincident", 32'({cnt_tick, busy, pos}), 32'h20);
    cyc(10);
    chk("lap_after_idle", 32'({busy, lap_done}), 32'h0);
    chk("lap_no_extra_tick", 32'(tick_cnt - base_t), 32'd16);
    chk("lap_clr_count", 32'(clr_cnt - base_c), 32'd1);
    chk("lap_pulse_count", 32'(lap_cnt), 32'd1);

    // Reset while running at position 7.
    sw_lap = 1'b0;
    btn_start = 1'b1;
    cyc(6);
    btn_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (pos == 4'd7 && busy === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("pos7_seen", 32'(seen), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", 32'({cnt_tick, cnt_clr, modo, pos, busy, lap_done}), 32'h0);
    cyc(1);
    base_t = tick_cnt;
    base_c = clr_cnt;
    rst = 1'b0;
    cyc(12);
    chk("post_reset_no_tick", 32'(tick_cnt - base_t), 32'd0);
    chk("post_reset_no_clr", 32'(clr_cnt - base_c), 32'd0);
    chk("post_reset_idle", 32'({busy, pos, lap_done}), 32'h0);

    chk("tick_clr_exclusive", 32'(both_hi), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
